// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM stage and data memory.
// Latency: req accepted at edge k -> dm_req from k+1; ack at edge m -> resp_valid in m+1.
// Backpressure: req_ready only in IDLE; one access in flight; dm_req held until dm_ack or timeout.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_write, req_whb, req_addr, req_wdata)
//   resp_valid/err/rdata     single-cycle registered completion
//   busy                     state != IDLE, pipeline stall source
//   dm_req/addr/wen/wdata    data memory access (registered, stable until ack)
//   dm_rdata/dm_ack          data memory return
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_whb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wen,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack
);

  // Access size codes (parameter_define.sv encoding).
  localparam logic [2:0] WHB_BYTE  = 3'b000;
  localparam logic [2:0] WHB_HALF  = 3'b001;
  localparam logic [2:0] WHB_WORD  = 3'b010;
  localparam logic [2:0] WHB_BYTEU = 3'b100;
  localparam logic [2:0] WHB_HALFU = 3'b101;

  // Counter value seen in the last allowed ACCESS cycle (counter starts at 0).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  whb_q, whb_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        dm_req_q, dm_req_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [3:0]  dm_wen_q, dm_wen_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  // Request decode: legality/alignment, lane enables and replicated store data.
  logic        req_ok;
  logic [3:0]  req_wen;
  logic [31:0] req_wrep;

  always_comb begin
    req_ok   = 1'b0;
    req_wen  = 4'b0000;
    req_wrep = req_wdata;
    case (req_whb)
      WHB_WORD: begin
        req_ok  = (req_addr[1:0] == 2'b00);
        req_wen = 4'b1111;
      end
      WHB_HALF, WHB_HALFU: begin
        req_ok   = ~req_addr[0];
        req_wen  = 4'b0011 << req_addr[1:0];
        req_wrep = {2{req_wdata[15:0]}};
      end
      WHB_BYTE, WHB_BYTEU: begin
        req_ok   = 1'b1;
        req_wen  = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and extension from the latched size/offset.
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  always_comb begin
    ld_shift = dm_rdata >> {off_q, 3'b000};
    ld_data  = ld_shift;
    case (whb_q)
      WHB_BYTE:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      WHB_BYTEU: ld_data = {24'b0, ld_shift[7:0]};
      WHB_HALF:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      WHB_HALFU: ld_data = {16'b0, ld_shift[15:0]};
      default:   ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    whb_d        = whb_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'b0;
    dm_req_d     = dm_req_q;
    dm_addr_d    = dm_addr_q;
    dm_wen_d     = dm_wen_q;
    dm_wdata_d   = dm_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          whb_d   = req_whb;
          off_d   = req_addr[1:0];
          if (req_ok) begin
            state_d    = S_ACCESS;
            cnt_d      = 8'd0;
            dm_req_d   = 1'b1;
            dm_addr_d  = {req_addr[31:2], 2'b00};
            dm_wen_d   = req_write ? req_wen : 4'b0000;
            dm_wdata_d = req_wrep;
          end else begin
            // Rejected requests never touch the memory bus.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        // Ack is checked first so an ack in the final allowed cycle still succeeds.
        if (dm_ack) begin
          state_d      = S_RESP;
          dm_req_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 32'b0 : ld_data;
        end else if (cnt_q == TO_LAST) begin
          state_d      = S_RESP;
          dm_req_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      whb_q        <= 3'b0;
      off_q        <= 2'b0;
      cnt_q        <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'b0;
      dm_req_q     <= 1'b0;
      dm_addr_q    <= 32'b0;
      dm_wen_q     <= 4'b0;
      dm_wdata_q   <= 32'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      whb_q        <= whb_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      dm_req_q     <= dm_req_d;
      dm_addr_q    <= dm_addr_d;
      dm_wen_q     <= dm_wen_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign dm_req     = dm_req_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wen     = dm_wen_q;
  assign dm_wdata   = dm_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with TIMEOUT=4.
// Expected responses are queued when a request is driven and compared when resp_valid fires.
// Memory side is driven per access by the stimulus task (ack cycle chosen per request).
module tb_lsu_ctrl;

  localparam int TO = 4;

  localparam logic [2:0] BYTE  = 3'b000;
  localparam logic [2:0] HALF  = 3'b001;
  localparam logic [2:0] WORD  = 3'b010;
  localparam logic [2:0] BYTEU = 3'b100;
  localparam logic [2:0] HALFU = 3'b101;
  localparam logic [2:0] ILLEG = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_whb;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        busy, dm_req, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wen;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_whb(req_whb), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .busy(busy), .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] whb, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (whb)
      BYTE:    return {{24{b[7]}}, b};
      BYTEU:   return {24'h0, b};
      HALF:    return {{16{h[15]}}, h};
      HALFU:   return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // Scoreboard consumer: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
        check("resp_rdata", resp_rdata, e[31:0]);
      end
    end
  end

  // One request from IDLE through completion. ack_cyc: ACCESS cycle (1-based) carrying
  // dm_ack, 0 = never. exp_n: expected number of cycles with dm_req high.
  task automatic do_access(input logic wr, input logic [2:0] whb, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd, input int ack_cyc,
                           input int exp_n, input logic exp_err, input logic [31:0] exp_rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_wen,
                           input logic [31:0] exp_wdata);
    int n;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    check("ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_whb = whb; req_addr = addr; req_wdata = wdata;
    sb_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    // Garbage on the request bus must be ignored while busy.
    req_valid = 1'b0; req_write = ~wr; req_whb = ILLEG; req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      if (!dm_req) break;
      n++;
      if (c == 1) begin
        check("dm_addr", dm_addr, exp_addr);
        check("dm_wen", {28'b0, dm_wen}, {28'b0, exp_wen});
        if (wr) check("dm_wdata", dm_wdata, exp_wdata);
      end
      if (c == ack_cyc) begin
        dm_ack = 1'b1; dm_rdata = rd;
      end
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_rdata = $urandom;
    end
    check("dm_req_cycles", n, exp_n);
    check("resp_timing", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    check("idle_after", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_whb = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; dm_ack = 1'b0; dm_rdata = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_dm_req", {31'b0, dm_req}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wen", {28'b0, dm_wen}, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loads with ack two cycles after dm_req rises.
    do_access(0, BYTE,  32'h103, 0, 32'h80FF_1234, 3, 3, 0, 32'hFFFF_FF80, 32'h100, 4'b0, 0);
    do_access(0, BYTEU, 32'h103, 0, 32'h80FF_1234, 3, 3, 0, 32'h0000_0080, 32'h100, 4'b0, 0);
    do_access(0, HALF,  32'h202, 0, 32'h9ABC_0000, 1, 1, 0, 32'hFFFF_9ABC, 32'h200, 4'b0, 0);
    do_access(0, HALFU, 32'h202, 0, 32'h9ABC_0000, 2, 2, 0, 32'h0000_9ABC, 32'h200, 4'b0, 0);
    do_access(0, WORD,  32'h204, 0, 32'hC0DE_F00D, 1, 1, 0, 32'hC0DE_F00D, 32'h204, 4'b0, 0);
    // Stores.
    do_access(1, HALF, 32'h12, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 2, 0, 32'h0,
              32'h10, 4'b1100, 32'hBEEF_BEEF);
    do_access(1, BYTE, 32'h11, 32'h0000_0055, 32'hFFFF_FFFF, 1, 1, 0, 32'h0,
              32'h10, 4'b0010, 32'h5555_5555);
    do_access(1, WORD, 32'h40, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1, 0, 32'h0,
              32'h40, 4'b1111, 32'h1234_5678);
    // Rejected requests: never reach the memory bus.
    do_access(0, WORD,  32'h6, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'b0, 0);
    do_access(0, HALF,  32'h3, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'b0, 0);
    do_access(1, ILLEG, 32'h8, 32'hAAAA_AAAA, 0, 0, 0, 1, 32'h0, 32'h0, 4'b0, 0);
    // Timeout and ack in the last allowed cycle.
    do_access(0, WORD, 32'h300, 0, 32'h1111_1111, 0, TO, 1, 32'h0, 32'h300, 4'b0, 0);
    do_access(0, WORD, 32'h300, 0, 32'h2222_2222, TO, TO, 0, 32'h2222_2222, 32'h300, 4'b0, 0);

    // Randomised aligned loads against the reference model.
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  w;
      logic [31:0] a, rd;
      int          ac;
      case ($urandom_range(0, 4))
        0: w = BYTE;  1: w = BYTEU; 2: w = HALF; 3: w = HALFU; default: w = WORD;
      endcase
      a = $urandom;
      if (w == WORD) a[1:0] = 2'b00;
      if (w == HALF || w == HALFU) a[0] = 1'b0;
      rd = $urandom;
      ac = $urandom_range(1, 3);
      do_access(0, w, a, 0, rd, ac, ac, 0, model_load(w, a[1:0], rd),
                {a[31:2], 2'b00}, 4'b0, 0);
    end

    // Reset while in ACCESS: dm_req drops, no response.
    req_valid = 1'b1; req_write = 1'b0; req_whb = WORD; req_addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_dm_req", {31'b0, dm_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_acc_dm_req", {31'b0, dm_req}, 32'd0);
    check("rst_acc_ready", {31'b0, req_ready}, 32'd1);
    check("rst_acc_resp", {31'b0, resp_valid}, 32'd0);

    // Stray ack in IDLE.
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_ack_resp", {31'b0, resp_valid}, 32'd0);
      check("stray_ack_busy", {31'b0, busy}, 32'd0);
    end
    dm_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the MEM pipeline stage and the data memory. It accepts one load or store request at a time, checks alignment, and runs a req/ack handshake with the data memory. It drives byte-lane write enables and replicated store data, then returns a lane-extracted, sign- or zero-extended load result as a single-cycle response. It also owns the bus-timeout and misalignment error reporting for data accesses.

## Interface
- TIMEOUT, 16: ACCESS-state cycles allowed without `dm_ack` before a bus error; legal range 1..255.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_whb  in  3  access size from parameter_define.sv: `WORD`, `HALF`, `HALFU`, `BYTE`, `BYTEU`.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with `resp_valid`: misaligned, illegal size code, or timeout.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- busy  out  1  state != IDLE; used as the pipeline stall source.
- dm_req  out  1  memory access strobe.
- dm_addr  out  32  `{addr[31:2],2'b00}`.
- dm_wen  out  4  byte write enables, active high; 0 for loads.
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  memory read word; valid when `dm_ack` is high.
- dm_ack  in  1  access complete.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on `req_valid`, latch `write`, `whb`, `addr` and `wdata`.
  - Aligned and legal: go to ACCESS.
  - Otherwise: go to RESP with err=1.
- Alignment rules:
  - `WORD` needs `addr[1:0]`=0.
  - `HALF`/`HALFU` need `addr[0]`=0.
  - Byte sizes are always aligned.
  - Any other `whb` code is illegal.
- ACCESS: `dm_req`=1 with registered `dm_addr`, `dm_wen` and `dm_wdata`, held stable until the ack.
  - `dm_ack`: capture `dm_rdata`, go to RESP with err=0.
  - Timeout counter reaches TIMEOUT with no ack: go to RESP with err=1.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins, err=0.
- RESP: `resp_valid`=1 for one cycle, then IDLE.
- Store lanes, with o=`addr[1:0]`:
  - `BYTE`/`BYTEU`: wdata `{4{wdata[7:0]}}`, wen `4'b0001<<o`.
  - `HALF`/`HALFU`: wdata `{2{wdata[15:0]}}`, wen `4'b0011<<o`.
  - `WORD`: wdata unchanged, wen `4'b1111`.
- Load result: s = `dm_rdata >> (8*o)`, then:
  - `WORD`: s.
  - `BYTE`: `{{24{s[7]}},s[7:0]}`.
  - `BYTEU`: `{24'b0,s[7:0]}`.
  - `HALF`: `{{16{s[15]}},s[15:0]}`.
  - `HALFU`: `{16'b0,s[15:0]}`.
- Stores complete with `resp_rdata`=0. Errors never assert `dm_req`.
- `dm_ack` outside ACCESS is ignored.
- Request inputs are not sampled outside IDLE.

## Timing
- Reset values: state IDLE, `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_err`=0.
- Also reset to 0: `resp_rdata`, `dm_req`, `dm_addr`, `dm_wen`, `dm_wdata`, timeout counter.
- `rst` takes priority in every state. Reset during ACCESS drops `dm_req` next edge and produces no response.
- Request accepted at edge k.
- `dm_req` is high from cycle k+1.
- Ack sampled at edge m gives `resp_valid` in cycle m+1 and IDLE at m+2.
- Zero-wait memory (ack in the first ACCESS cycle): 3 cycles from acceptance to the next `req_ready`.
- Misaligned/illegal request: `resp_valid` with err=1 in cycle k+1.
- Timeout: counter clears on entry to ACCESS and increments each ACCESS cycle without ack. Error response follows exactly TIMEOUT ACCESS cycles.
- `resp_*` outputs are registered. `busy` and `req_ready` are decoded from state only.

## Test plan
- Load `BYTE`, addr 0x103, `dm_rdata`=0x80FF_1234, ack 2 cycles after `dm_req` -> `dm_addr`=0x100, `dm_wen`=0, `resp_rdata`=0xFFFF_FF80, err=0. Repeat with `BYTEU` -> 0x0000_0080.
- Load `HALF`, addr 0x202, `dm_rdata`=0x9ABC_0000 -> 0xFFFF_9ABC. `HALFU` -> 0x0000_9ABC. `WORD`, addr 0x204 -> `dm_rdata` unchanged.
- Store `HALF`, addr 0x12, wdata 0xDEAD_BEEF -> `dm_wen`=4'b1100, `dm_wdata`=0xBEEF_BEEF, `dm_addr`=0x10, `resp_rdata`=0. Store `BYTE`, addr 0x11, wdata 0x55 -> wen 4'b0010, wdata 0x5555_5555.
- Misaligned `WORD`, addr 0x6 -> no `dm_req`, `resp_valid`/`resp_err`=1 the cycle after acceptance. Illegal `whb` code -> same response.
- Timeout with TIMEOUT=4, ack never asserted -> `dm_req` high exactly 4 cycles, then `resp_err`=1. Ack on the 4th ACCESS cycle -> err=0.
- `rst` asserted during ACCESS -> next cycle `dm_req`=0, `req_ready`=1, no `resp_valid`. A stray `dm_ack` in IDLE -> no response.
